bias_stream: RTL and testbench

BIAS_STREAM -- requirements
Module: bias_stream

---
 rtl/bias_pkg.sv | 21 ++
 rtl/rom.sv | 32 +++
 rtl/bias_stream.sv | 182 ++++++++++++++++++
 tb/tb_bias_stream.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// ----------------------------------------------------------------------------
// bias_pkg
//   Shared definitions for the bias_stream block: the run-control state
//   encoding and the counter-width helper used to size address and pass
//   counters.
// ----------------------------------------------------------------------------
package bias_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/rom.sv
// ----------------------------------------------------------------------------
// rom
//   Single-port synchronous ROM with one cycle of read latency: q is valid
//   the cycle after ce is sampled high. The array contents are loaded
//   externally; mem_file names the intended initialisation image.
//
//   Ports
//     clk   in   clock, rising edge
//     ce    in   read enable
//     addr  in   word address
//     q     out  read data
// ----------------------------------------------------------------------------
module rom #(
  parameter int    mem_size   = 64,
  parameter int    data_width = 16,
  parameter string mem_file   = ""
) (
  input  logic                                               clk,
  input  logic                                               ce,
  input  logic [((mem_size > 1) ? $clog2(mem_size) : 1)-1:0] addr,
  output logic [data_width-1:0]                              q
);

  logic [data_width-1:0] mem [mem_size];

  // NOTE: neither the array nor q is reset -- a ROM holds its contents, and
  // the consumer ignores q unless it issued the read the cycle before.
  always_ff @(posedge clk) begin
    if (ce) q <= mem[addr];
  end

endmodule

// File: rtl/bias_stream.sv
// ----------------------------------------------------------------------------
// bias_stream
//   Streams the bias table ROM[0..N_CH-1] N_REP times into a FIFO-style
//   write port. ROM reads are issued ahead of the consumer and land in a
//   2-entry skid buffer whose head drives output_V_din, so the stream runs
//   at one word per cycle and freezes cleanly when the FIFO is full.
//
//   Optional feature (macro BIAS_STREAM_AP_CTRL_EN):
//     defined   -> ap_start/ap_done/ap_idle handshake; a run starts on
//                  ap_start in IDLE.
//     undefined -> one run starts right after reset release, then the block
//                  stays quiet until the next reset.
//
//   Ports
//     ap_clk           in   clock, rising edge
//     ap_rst_n         in   synchronous reset, active low
//     ap_start         in   start a run (BIAS_STREAM_AP_CTRL_EN only)
//     ap_done          out  1-cycle pulse after the last write (ditto)
//     ap_idle          out  high while waiting for ap_start (ditto)
//     output_V_din     out  bias word offered to the FIFO
//     output_V_full_n  in   FIFO can accept a word
//     output_V_write   out  word is written this cycle
// ----------------------------------------------------------------------------
module bias_stream
  import bias_pkg::*;
#(
  parameter int    N_CH       = 64,
  parameter int    N_REP      = 1,
  parameter int    DATA_WIDTH = 16,
  parameter string MEM_FILE   = "./bias.mem"
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
`ifdef BIAS_STREAM_AP_CTRL_EN
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
`endif
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);

  localparam int AW = clog2_min1(N_CH);
  localparam int PW = clog2_min1(N_REP + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_CH - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(N_REP - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [PW-1:0]         pass_q, pass_d;
  logic                  inflight_q, inflight_d;   // ROM read issued last cycle
  logic [1:0]            count_q, count_d;         // skid buffer occupancy
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;           // head, drives output_V_din
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic                  start;
  logic                  pop;
  logic                  push;
  logic                  rom_ce;
  logic [1:0]            occ_after_pop;
  logic [DATA_WIDTH-1:0] rom_q;

`ifdef BIAS_STREAM_AP_CTRL_EN
  assign start   = ap_start;
  assign ap_idle = (state_q == ST_IDLE) || !ap_rst_n;
  assign ap_done = (state_q == ST_DONE) && ap_rst_n;
`else
  // Remembers that this reset period already had its run.
  logic launched_q, launched_d;

  assign start      = ~launched_q;
  assign launched_d = launched_q | (state_q == ST_IDLE);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) launched_q <= 1'b0;
    else           launched_q <= launched_d;
  end
`endif

  // Outputs are gated by reset so they read 0 for the whole reset cycle.
  assign pop  = ap_rst_n && (count_q != 2'd0) && output_V_full_n;
  assign push = inflight_q;

  // Occupancy once this cycle's write leaves and the in-flight word lands.
  // Counting the departing word is what lets reads keep pace with writes.
  assign occ_after_pop = count_q - {1'b0, pop} + {1'b0, inflight_q};
  assign rom_ce        = ap_rst_n && (state_q == ST_RUN) && (occ_after_pop < 2'd2);

  assign output_V_write = pop;
  assign output_V_din   = ap_rst_n ? buf0_q : '0;

  // NOTE: every signal written below gets its default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pass_d     = pass_q;
    inflight_d = rom_ce;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = '0;
          pass_d  = '0;
        end
      end
      ST_RUN: begin
        if (rom_ce) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pass_d = pass_q + PW'(1);
          end else begin
            addr_d = addr_q + AW'(1);
          end
          if (addr_q == LAST_ADDR && pass_q == LAST_PASS) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Nothing left buffered or in flight: this cycle held the last write.
        if (occ_after_pop == 2'd0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = rom_q;
        else                 buf1_d = rom_q;
      end
      2'b01: buf0_d = buf1_q;
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = rom_q;
        end else begin
          buf0_d = buf1_q;
          buf1_d = rom_q;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments and a reset sampled on the
  // clock edge; a mid-run reset therefore drops buffered and in-flight words.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  rom #(
    .mem_size  (N_CH),
    .data_width(DATA_WIDTH),
    .mem_file  (MEM_FILE)
  ) u_rom (
    .clk (ap_clk),
    .ce  (rom_ce),
    .addr(addr_q),
    .q   (rom_q)
  );

endmodule

// File: tb/tb_bias_stream.sv
// ----------------------------------------------------------------------------
// tb_bias_stream
//   Two instances: dut_a (N_CH=4, N_REP=2, ROM 10,20,30,40) and dut_b
//   (N_CH=1, N_REP=3, ROM 7). The reference model is the expected word list
//   plus the rule that, from the second cycle after a run starts, a word is
//   written on every cycle with full_n=1 until the list is exhausted, and the
//   pending word is always visible on din. Builds with or without
//   BIAS_STREAM_AP_CTRL_EN.
// ----------------------------------------------------------------------------
module tb_bias_stream;

  localparam int DW = 16;

  localparam int M_FULL    = 0;
  localparam int M_STALL   = 1;
  localparam int M_TOGGLE  = 2;
  localparam int M_RANDOM  = 3;
  localparam int M_RESET   = 4;
  localparam int M_RESTART = 5;

`ifdef BIAS_STREAM_AP_CTRL_EN
  localparam bit RESTART_BY_RESET = 1'b0;
`else
  localparam bit RESTART_BY_RESET = 1'b1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b, full_a, full_b, wr_a, wr_b;
  logic [DW-1:0] din_a, din_b;
`ifdef BIAS_STREAM_AP_CTRL_EN
  logic          start_a, start_b, done_a, done_b, idle_a, idle_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int rom_a [4] = '{10, 20, 30, 40};
  int rom_b [1] = '{7};

  bias_stream #(.N_CH(4), .N_REP(2), .DATA_WIDTH(DW), .MEM_FILE("")) dut_a (
    .ap_clk         (clk),
    .ap_rst_n       (rst_a),
`ifdef BIAS_STREAM_AP_CTRL_EN
    .ap_start       (start_a),
    .ap_done        (done_a),
    .ap_idle        (idle_a),
`endif
    .output_V_din   (din_a),
    .output_V_full_n(full_a),
    .output_V_write (wr_a)
  );

  bias_stream #(.N_CH(1), .N_REP(3), .DATA_WIDTH(DW), .MEM_FILE("")) dut_b (
    .ap_clk         (clk),
    .ap_rst_n       (rst_b),
`ifdef BIAS_STREAM_AP_CTRL_EN
    .ap_start       (start_b),
    .ap_done        (done_b),
    .ap_idle        (idle_b),
`endif
    .output_V_din   (din_b),
    .output_V_full_n(full_b),
    .output_V_write (wr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, want);
    end
  endtask

  task automatic set_rst(input bit sel, input logic v);
    if (sel) rst_b = v; else rst_a = v;
  endtask

  task automatic set_full(input bit sel, input logic v);
    if (sel) full_b = v; else full_a = v;
  endtask

`ifdef BIAS_STREAM_AP_CTRL_EN
  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask
`endif

  // Leaves the bench #1 after a clock edge such that the next edge starts
  // the run (reset release or sampled ap_start).
  task automatic start_run(input bit sel, input bit do_reset);
    if (do_reset) begin
      @(posedge clk); #1;
      set_rst(sel, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      set_rst(sel, 1'b1);
`ifdef BIAS_STREAM_AP_CTRL_EN
      set_start(sel, 1'b1);
`endif
    end else begin
`ifdef BIAS_STREAM_AP_CTRL_EN
      @(posedge clk); #1;
      set_start(sel, 1'b1);
`endif
    end
  endtask

  // Cycle n counts from the edge that starts the run.
  task automatic run_check(input bit sel, input int mode);
    int   q[$];
    int   idx     = 0;
    int   last_wr = -1;
    int   dut_wr  = 0;
    bit   aborted = 1'b0;
    bit   f, exp_wr;
    logic wr;
    logic [DW-1:0] din;

    if (sel) begin
      for (int r = 0; r < 3; r++) q.push_back(rom_b[0]);
    end else begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 4; c++) q.push_back(rom_a[c]);
    end

    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
`ifdef BIAS_STREAM_AP_CTRL_EN
      if (n == 0) set_start(sel, 1'b0);
      if (mode == M_RESTART && n == 3) set_start(sel, 1'b1);
      if (mode == M_RESTART && n == 4) set_start(sel, 1'b0);
`endif
      if (mode == M_RESET && idx == 3) begin
        set_rst(sel, 1'b0);
        @(negedge clk);
        check("reset_write", sel ? wr_b : wr_a, 1'b0);
        check("reset_din", sel ? din_b : din_a, '0);
        @(posedge clk); #1;
        set_rst(sel, 1'b1);
        aborted = 1'b1;
        break;
      end
      case (mode)
        M_STALL:  f = !(n >= 3 && n <= 6);
        M_TOGGLE: f = ((n % 2) == 0);
        M_RANDOM: f = 1'($urandom_range(0, 1));
        default:  f = 1'b1;
      endcase
      set_full(sel, f);

      @(negedge clk);
      wr  = sel ? wr_b : wr_a;
      din = sel ? din_b : din_a;
      exp_wr = (n >= 2) && f && (idx < q.size());
      check("write", wr, exp_wr);
      if (n >= 2 && idx < q.size()) check("din", din, q[idx]);
`ifdef BIAS_STREAM_AP_CTRL_EN
      check("ap_done", sel ? done_b : done_a, (last_wr >= 0) && (n == last_wr + 1));
      check("ap_idle", sel ? idle_b : idle_a, (last_wr >= 0) && (n >= last_wr + 2));
`endif
      if (wr) dut_wr++;
      if (exp_wr) begin
        idx++;
        if (idx == q.size()) last_wr = n;
      end
      if (last_wr >= 0 && n >= last_wr + 4) break;
    end
    if (!aborted) check("write_count", dut_wr, q.size());
  endtask

  initial begin
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    full_a = 1'b1;
    full_b = 1'b1;
`ifdef BIAS_STREAM_AP_CTRL_EN
    start_a = 1'b0;
    start_b = 1'b0;
`endif
    foreach (rom_a[i]) dut_a.u_rom.mem[i] = DW'(rom_a[i]);
    dut_b.u_rom.mem[0] = DW'(rom_b[0]);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state_write", wr_a, 1'b0);
    check("reset_state_din", din_a, '0);
`ifdef BIAS_STREAM_AP_CTRL_EN
    check("reset_state_idle", idle_a, 1'b1);
    check("reset_state_done", done_a, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_start_write", wr_a, 1'b0);
      check("no_start_idle", idle_a, 1'b1);
    end
`endif

    start_run(1'b0, RESTART_BY_RESET); run_check(1'b0, M_FULL);
    start_run(1'b0, RESTART_BY_RESET); run_check(1'b0, M_STALL);
    start_run(1'b0, RESTART_BY_RESET); run_check(1'b0, M_TOGGLE);
    start_run(1'b0, RESTART_BY_RESET); run_check(1'b0, M_RESET);
    start_run(1'b0, 1'b0);             run_check(1'b0, M_FULL);
`ifdef BIAS_STREAM_AP_CTRL_EN
    start_run(1'b0, 1'b0); run_check(1'b0, M_RESTART);
    start_run(1'b0, 1'b0); run_check(1'b0, M_FULL);
`else
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("quiet_after_done", wr_a, 1'b0);
    end
`endif

    start_run(1'b1, RESTART_BY_RESET); run_check(1'b1, M_FULL);
    start_run(1'b1, RESTART_BY_RESET); run_check(1'b1, M_RANDOM);

    for (int k = 0; k < 4; k++) begin
      foreach (rom_a[i]) begin
        rom_a[i] = int'($urandom_range(0, 65535));
        dut_a.u_rom.mem[i] = DW'(rom_a[i]);
      end
      start_run(1'b0, RESTART_BY_RESET);
      run_check(1'b0, M_RANDOM);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
